// File: rtl/ahbl_slave_mem.sv
// AHB-Lite completer memory with programmable wait states and two-cycle ERROR response.
// Optional random extra waits from an 8-bit LFSR when AHBL_SLV_RANDWAIT_EN is defined.
module ahbl_slave_mem #(
  parameter int MEM_AWIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic [31:0] HWDATA,
  input  logic        HREADYIN,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  // Handshake: a transfer is accepted in the address phase when HSEL & HREADYIN & HTRANS[1]
  // while this slave is ready; its data phase ends at the first edge with HREADYOUT=1.
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                  state_q, state_d;
  logic [MEM_AWIDTH-1:0]   waddr_q, waddr_d;
  logic [1:0]              boff_q, boff_d;
  logic [1:0]              size_q, size_d;
  logic                    write_q, write_d;
  logic [4:0]              wcnt_q, wcnt_d;
  logic [31:0]             mem_q [2**MEM_AWIDTH];

  logic       accept;
  logic       can_accept;
  logic       illegal;
  logic [4:0] waits;
  logic [3:0] lane_en;
  logic       unused_sig;

  assign unused_sig = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  assign accept     = HSEL & HREADYIN & HTRANS[1];
  assign can_accept = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
  assign illegal    = (HSIZE > 3'd2)
                    | ((HSIZE == 3'd1) & HADDR[0])
                    | ((HSIZE == 3'd2) & (|HADDR[1:0]))
                    | (|HADDR[31:MEM_AWIDTH+2]);

`ifdef AHBL_SLV_RANDWAIT_EN
  logic [7:0] lfsr_q;
  logic       lfsr_adv;

  assign lfsr_adv = can_accept & accept & ~illegal;
  assign waits    = 5'(WAIT_STATES) + {3'b000, lfsr_q[1:0]};

  // Fibonacci taps 8,6,5,4; the value in use for this transfer is the pre-advance one.
  always_ff @(posedge HCLK) begin
    if (HRESET) lfsr_q <= 8'hA5;
    else if (lfsr_adv) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
`else
  assign waits = 5'(WAIT_STATES);
`endif

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    boff_d  = boff_q;
    size_d  = size_q;
    write_d = write_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_WAIT: begin
        if (wcnt_q <= 5'd1) begin
          state_d = S_DATA;
          wcnt_d  = 5'd0;
        end else begin
          wcnt_d = wcnt_q - 5'd1;
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          waddr_d = HADDR[MEM_AWIDTH+1:2];
          boff_d  = HADDR[1:0];
          size_d  = HSIZE[1:0];
          write_d = HWRITE;
          if (illegal) begin
            state_d = S_ERR1;
          end else if (waits != 5'd0) begin
            state_d = S_WAIT;
            wcnt_d  = waits;
          end else begin
            state_d = S_DATA;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      waddr_q <= '0;
      boff_q  <= 2'd0;
      size_q  <= 2'd0;
      write_q <= 1'b0;
      wcnt_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      boff_q  <= boff_d;
      size_q  <= size_d;
      write_q <= write_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    lane_en = 4'b1111;
    if (size_q == 2'd0)      lane_en = 4'b0001 << boff_q;
    else if (size_q == 2'd1) lane_en = boff_q[1] ? 4'b1100 : 4'b0011;
  end

  // Memory is never reset; a write still pending when reset arrives is dropped.
  always_ff @(posedge HCLK) begin
    if (!HRESET && (state_q == S_DATA) && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem_q[waddr_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HREADYOUT = (state_q != S_WAIT) && (state_q != S_ERR1);
  assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign HRDATA    = ((state_q == S_DATA) && !write_q) ? mem_q[waddr_q] : 32'h0;

endmodule

// File: tb/tb_ahbl_slave_mem.sv
// Bench for ahbl_slave_mem: three instances (0, 2 and 3 wait states) checked against a
// byte-addressed reference memory with directed and randomized transfers.
module tb_ahbl_slave_mem;

  localparam int ND = 3;

  logic        clk;
  logic        rst;
  logic        hsel      [ND];
  logic [31:0] haddr     [ND];
  logic [1:0]  htrans    [ND];
  logic        hwrite    [ND];
  logic [2:0]  hsize     [ND];
  logic [31:0] hwdata    [ND];
  logic        hreadyin  [ND];
  logic        hreadyout [ND];
  logic        hresp     [ND];
  logic [31:0] hrdata    [ND];
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;

  logic [7:0]  mb [ND][64];
  int          n_checks;
  int          n_errors;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_dut
    ahbl_slave_mem #(.MEM_AWIDTH(10), .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3))) u_dut (
      .HCLK      (clk),
      .HRESET    (rst),
      .HSEL      (hsel[g]),
      .HADDR     (haddr[g]),
      .HTRANS    (htrans[g]),
      .HWRITE    (hwrite[g]),
      .HSIZE     (hsize[g]),
      .HBURST    (hburst),
      .HPROT     (hprot),
      .HMASTLOCK (hmastlock),
      .HWDATA    (hwdata[g]),
      .HREADYIN  (hreadyin[g]),
      .HREADYOUT (hreadyout[g]),
      .HRESP     (hresp[g]),
      .HRDATA    (hrdata[g])
    );
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int d, input logic [31:0] addr);
    int b;
    b = int'(addr & 32'h3C);
    return {mb[d][b+3], mb[d][b+2], mb[d][b+1], mb[d][b]};
  endfunction

  function automatic bit is_illegal(input logic [31:0] addr, input logic [2:0] sz);
    return (sz > 3'd2) || (sz == 3'd1 && addr[0]) || (sz == 3'd2 && addr[1:0] != 2'b00)
           || (addr >= 32'h1000);
  endfunction

  task automatic idle_bus(input int d);
    hsel[d]     = 1'b0;
    htrans[d]   = 2'b00;
    hwrite[d]   = 1'b0;
    hsize[d]    = 3'd0;
    haddr[d]    = 32'h0;
    hreadyin[d] = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: one non-pipelined transfer, checked cycle by cycle against the reference memory
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [2:0] sz, input logic [31:0] wd);
    bit          ill;
    int          lowc;
    int          bad_resp;
    int          bad_rd;
    int          exp_low;
    logic [31:0] exp_rd;
    ill     = is_illegal(addr, sz);
    exp_low = ill ? 1 : ws_of(d);
    exp_rd  = (!wr && !ill) ? model_word(d, addr) : 32'h0;
    hsel[d]   = 1'b1;
    htrans[d] = 2'b10;
    haddr[d]  = addr;
    hwrite[d] = wr;
    hsize[d]  = sz;
    step();
    idle_bus(d);
    hwdata[d] = wd;
    lowc = 0;
    bad_resp = 0;
    bad_rd = 0;
    while (hreadyout[d] !== 1'b1 && lowc < 40) begin
      if (hresp[d] !== ill) bad_resp++;
      if (hrdata[d] !== 32'h0) bad_rd++;
      lowc++;
      step();
    end
    check("low_cycles", 32'(lowc), 32'(exp_low));
    check("resp_while_low", 32'(bad_resp), 32'd0);
    check("rdata_while_low", 32'(bad_rd), 32'd0);
    check("resp_final", {31'd0, hresp[d]}, {31'd0, ill});
    check("rdata", hrdata[d], exp_rd);
    if (wr && !ill) begin
      for (int i = 0; i < (1 << sz); i++)
        mb[d][int'(addr) + i] = wd[8*((int'(addr) + i) % 4) +: 8];
    end
    step();
  endtask

  task automatic check_idle_outputs(input string tag, input int d);
    check({tag, "_ready"}, {31'd0, hreadyout[d]}, 32'd1);
    check({tag, "_resp"},  {31'd0, hresp[d]},     32'd0);
    check({tag, "_rdata"}, hrdata[d],             32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    int          d;
    n_checks  = 0;
    n_errors  = 0;
    hburst    = 3'b001;
    hprot     = 4'b0011;
    hmastlock = 1'b0;
    rst       = 1'b1;
    for (int i = 0; i < ND; i++) begin
      idle_bus(i);
      hwdata[i] = 32'h0;
    end
    repeat (3) step();
    for (int i = 0; i < ND; i++) check_idle_outputs("reset", i);
    rst = 1'b0;
    step();

    for (int i = 0; i < ND; i++)
      for (int w = 0; w < 16; w++) xfer(i, 1'b1, 32'(w * 4), 3'd2, $urandom());

    // zero-wait word, byte and halfword accesses
    xfer(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    xfer(0, 1'b0, 32'h10, 3'd2, 32'h0);
    check("word_model", model_word(0, 32'h10), 32'hDEADBEEF);
    xfer(0, 1'b1, 32'h13, 3'd0, 32'hA5000000);
    xfer(0, 1'b0, 32'h10, 3'd2, 32'h0);
    xfer(0, 1'b1, 32'h10, 3'd1, 32'h00001234);
    xfer(0, 1'b0, 32'h10, 3'd2, 32'h0);
    check("half_model", model_word(0, 32'h10), 32'hA5AD1234);

    // wait-state read and the two error cases
    xfer(1, 1'b0, 32'h10, 3'd2, 32'h0);
    xfer(1, 1'b1, 32'h11, 3'd1, 32'hFFFFFFFF);
    xfer(1, 1'b0, 32'h1000, 3'd2, 32'h0);
    xfer(1, 1'b0, 32'h10, 3'd2, 32'h0);

    // HREADYIN low: request must be ignored
    hsel[0] = 1'b1; htrans[0] = 2'b10; hwrite[0] = 1'b1; haddr[0] = 32'h10;
    hsize[0] = 3'd2; hreadyin[0] = 1'b0;
    step();
    check_idle_outputs("hreadyin_low", 0);
    idle_bus(0);
    hwdata[0] = 32'hFFFFFFFF;
    step();
    xfer(0, 1'b0, 32'h10, 3'd2, 32'h0);

    // pipelined write then read of the same word
    hsel[0] = 1'b1; htrans[0] = 2'b10; hwrite[0] = 1'b1; haddr[0] = 32'h20; hsize[0] = 3'd2;
    step();
    check("pipe_wr_ready", {31'd0, hreadyout[0]}, 32'd1);
    hwdata[0] = 32'h11223344;
    hwrite[0] = 1'b0;
    step();
    for (int i = 0; i < 4; i++) mb[0][32 + i] = 8'(32'h11223344 >> (8 * i));
    idle_bus(0);
    check("pipe_rd_ready", {31'd0, hreadyout[0]}, 32'd1);
    check("pipe_rd_resp", {31'd0, hresp[0]}, 32'd0);
    check("pipe_rd_data", hrdata[0], 32'h11223344);
    step();

    // reset in the middle of a waited write drops the write
    hsel[2] = 1'b1; htrans[2] = 2'b10; hwrite[2] = 1'b1; haddr[2] = 32'h10; hsize[2] = 3'd2;
    step();
    idle_bus(2);
    hwdata[2] = 32'hCAFEF00D;
    check("rst_pre_wait", {31'd0, hreadyout[2]}, 32'd0);
    step();
    rst = 1'b1;
    step();
    check_idle_outputs("mid_reset", 2);
    step();
    rst = 1'b0;
    step();
    xfer(2, 1'b0, 32'h10, 3'd2, 32'h0);

    // randomized transfers
    for (int n = 0; n < 200; n++) begin
      d  = int'($urandom_range(0, ND - 1));
      sz = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) sz = 3'($urandom_range(4, 7));
      a = 32'($urandom_range(0, 63));
      if (sz <= 3'd2 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 7) == 0) a = 32'h1000 | $urandom();
      xfer(d, 1'($urandom_range(0, 1)), a, sz, $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
